// File: rtl/uart_tx_baud.sv
// uart_tx_baud: selectable-baud UART transmitter, one 8N1 frame per accepted Enable, LSB first.
// Optional macro UART_TX_PARITY_EN inserts an even-parity bit before the stop bit (8E1).
module uart_tx_baud #(
    parameter int CLK_FREQ = 100000000,
    parameter int CNT_W    = 17
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [2:0] BR_Select,
    input  logic [7:0] Tx_Parallel,
    input  logic       Enable,
    output logic       Tx_Serial,
    output logic       Busy,
    output logic       Done
);

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_START  = 3'd1,
        ST_DATA   = 3'd2,
`ifdef UART_TX_PARITY_EN
        ST_PARITY = 3'd4,
`endif
        ST_STOP   = 3'd3
    } state_t;

    // Last count value of one bit period; integer truncation of CLK_FREQ/baud, minus one.
    function automatic logic [CNT_W-1:0] bit_last(input logic [2:0] sel);
        logic [CNT_W-1:0] cyc;
        case (sel)
            3'd0:    cyc = CNT_W'(CLK_FREQ / 1200 - 1);
            3'd1:    cyc = CNT_W'(CLK_FREQ / 2400 - 1);
            3'd2:    cyc = CNT_W'(CLK_FREQ / 4800 - 1);
            3'd3:    cyc = CNT_W'(CLK_FREQ / 9600 - 1);
            3'd4:    cyc = CNT_W'(CLK_FREQ / 19200 - 1);
            3'd5:    cyc = CNT_W'(CLK_FREQ / 38400 - 1);
            3'd6:    cyc = CNT_W'(CLK_FREQ / 57600 - 1);
            3'd7:    cyc = CNT_W'(CLK_FREQ / 115200 - 1);
            default: cyc = CNT_W'(CLK_FREQ / 115200 - 1);
        endcase
        return cyc;
    endfunction

`ifdef UART_TX_PARITY_EN
    function automatic logic even_parity(input logic [7:0] d);
        return ^d;
    endfunction
`endif

    state_t           state_r;
    state_t           state_s;
    logic [CNT_W-1:0] cnt_r;
    logic [CNT_W-1:0] cnt_s;
    logic [2:0]       idx_r;
    logic [2:0]       idx_s;
    logic [7:0]       shift_r;
    logic [7:0]       shift_s;
    logic [2:0]       sel_r;
    logic [2:0]       sel_s;
`ifdef UART_TX_PARITY_EN
    logic             parity_r;
    logic             parity_s;
`endif
    logic [CNT_W-1:0] bit_last_s;
    logic             bit_end_s;
    logic             tx_r;
    logic             tx_s;
    logic             busy_r;
    logic             busy_s;
    logic             done_r;
    logic             done_s;

    // Timing always follows the select latched at frame start, never the live switches.
    assign bit_last_s = bit_last(sel_r);
    assign bit_end_s  = (cnt_r == bit_last_s);

    // State, counters and latched frame data.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r  <= ST_IDLE;
            cnt_r    <= {CNT_W{1'b0}};
            idx_r    <= 3'd0;
            shift_r  <= 8'h00;
            sel_r    <= 3'd0;
`ifdef UART_TX_PARITY_EN
            parity_r <= 1'b0;
`endif
        end else begin
            state_r  <= state_s;
            cnt_r    <= cnt_s;
            idx_r    <= idx_s;
            shift_r  <= shift_s;
            sel_r    <= sel_s;
`ifdef UART_TX_PARITY_EN
            parity_r <= parity_s;
`endif
        end
    end

    // Next-state and datapath update; Enable is only looked at in IDLE, so it is never queued.
    always_comb begin
        state_s  = state_r;
        cnt_s    = cnt_r;
        idx_s    = idx_r;
        shift_s  = shift_r;
        sel_s    = sel_r;
`ifdef UART_TX_PARITY_EN
        parity_s = parity_r;
`endif
        case (state_r)
            ST_IDLE: begin
                cnt_s = {CNT_W{1'b0}};
                idx_s = 3'd0;
                if (Enable) begin
                    state_s  = ST_START;
                    shift_s  = Tx_Parallel;
                    sel_s    = BR_Select;
`ifdef UART_TX_PARITY_EN
                    parity_s = even_parity(Tx_Parallel);
`endif
                end else begin
                    state_s = ST_IDLE;
                end
            end
            ST_START: begin
                if (bit_end_s) begin
                    state_s = ST_DATA;
                    cnt_s   = {CNT_W{1'b0}};
                end else begin
                    cnt_s = cnt_r + 1'b1;
                end
            end
            ST_DATA: begin
                if (bit_end_s) begin
                    cnt_s   = {CNT_W{1'b0}};
                    shift_s = {1'b0, shift_r[7:1]};
                    idx_s   = idx_r + 3'd1;
                    if (idx_r == 3'd7) begin
`ifdef UART_TX_PARITY_EN
                        state_s = ST_PARITY;
`else
                        state_s = ST_STOP;
`endif
                    end else begin
                        state_s = ST_DATA;
                    end
                end else begin
                    cnt_s = cnt_r + 1'b1;
                end
            end
`ifdef UART_TX_PARITY_EN
            ST_PARITY: begin
                if (bit_end_s) begin
                    state_s = ST_STOP;
                    cnt_s   = {CNT_W{1'b0}};
                end else begin
                    cnt_s = cnt_r + 1'b1;
                end
            end
`endif
            ST_STOP: begin
                if (bit_end_s) begin
                    state_s = ST_IDLE;
                    cnt_s   = {CNT_W{1'b0}};
                end else begin
                    cnt_s = cnt_r + 1'b1;
                end
            end
            default: begin
                state_s = ST_IDLE;
                cnt_s   = {CNT_W{1'b0}};
                idx_s   = 3'd0;
            end
        endcase
    end

    // Outputs decoded from the next state so the registered pins line up with the state register.
    always_comb begin
        tx_s   = 1'b1;
        busy_s = 1'b0;
        case (state_s)
            ST_IDLE: begin
                tx_s   = 1'b1;
                busy_s = 1'b0;
            end
            ST_START: begin
                tx_s   = 1'b0;
                busy_s = 1'b1;
            end
            ST_DATA: begin
                tx_s   = shift_s[0];
                busy_s = 1'b1;
            end
`ifdef UART_TX_PARITY_EN
            ST_PARITY: begin
                tx_s   = parity_r;
                busy_s = 1'b1;
            end
`endif
            ST_STOP: begin
                tx_s   = 1'b1;
                busy_s = 1'b1;
            end
            default: begin
                tx_s   = 1'b1;
                busy_s = 1'b0;
            end
        endcase
        done_s = (state_r == ST_STOP) && bit_end_s;
    end

    // Registered output pins; reset mid-frame drops the line high with no Done.
    always_ff @(posedge clk) begin
        if (rst) begin
            tx_r   <= 1'b1;
            busy_r <= 1'b0;
            done_r <= 1'b0;
        end else begin
            tx_r   <= tx_s;
            busy_r <= busy_s;
            done_r <= done_s;
        end
    end

    assign Tx_Serial = tx_r;
    assign Busy      = busy_r;
    assign Done      = done_r;

endmodule

// File: tb/tb_uart_tx_baud.sv
// Scoreboard bench for uart_tx_baud: stimulus pushes expected frames, a negedge monitor
// decodes the serial line per Busy window and compares. Runs the DUT at 10 MHz to keep frames short.
module tb_uart_tx_baud;

    localparam int CLK_FREQ = 10000000;
`ifdef UART_TX_PARITY_EN
    localparam int NB = 11;
`else
    localparam int NB = 10;
`endif

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [2:0] BR_Select = 3'd0;
    logic [7:0] Tx_Parallel = 8'h00;
    logic       Enable = 1'b0;
    logic       Tx_Serial;
    logic       Busy;
    logic       Done;

    int checks = 0;
    int errors = 0;

    typedef struct {
        logic [7:0] data;
        int         bcyc;
        int         len;
        bit         done;
        int         gap;
    } exp_t;

    exp_t sb_q[$];

    uart_tx_baud #(.CLK_FREQ(CLK_FREQ), .CNT_W(17)) dut (
        .clk(clk), .rst(rst), .BR_Select(BR_Select), .Tx_Parallel(Tx_Parallel),
        .Enable(Enable), .Tx_Serial(Tx_Serial), .Busy(Busy), .Done(Done)
    );

    always #5 clk = ~clk;

    // Hand-computed 10 MHz bit periods: 10e6 / baud, truncated.
    function automatic int bcyc_of(input logic [2:0] sel);
        case (sel)
            3'd0: return 8333;
            3'd1: return 4166;
            3'd2: return 2083;
            3'd3: return 1041;
            3'd4: return 520;
            3'd5: return 260;
            3'd6: return 173;
            default: return 86;
        endcase
    endfunction

    function automatic logic frame_bit(input logic [7:0] d, input int slot);
        if (slot == 0) return 1'b0;
        else if (slot <= 8) return d[slot-1];
`ifdef UART_TX_PARITY_EN
        else if (slot == 9) return ^d;
`endif
        else return 1'b1;
    endfunction

    task automatic check(input string name, input int act, input int req);
        checks++;
        if (act != req) begin
            errors++;
            $display("FAIL %s: got %0d, expected %0d", name, act, req);
        end
    endtask

    // Caller is at a negedge; len < 0 means a complete frame ending in Done.
    task automatic send(input logic [2:0] sel, input logic [7:0] d, input int len, input int gap);
        exp_t e;
        BR_Select   = sel;
        Tx_Parallel = d;
        Enable      = 1'b1;
        e.data = d;
        e.bcyc = bcyc_of(sel);
        e.len  = (len < 0) ? NB * e.bcyc : len;
        e.done = (len < 0);
        e.gap  = gap;
        sb_q.push_back(e);
        @(negedge clk);
        Enable = 1'b0;
    endtask

    task automatic pulse_only(input logic [2:0] sel, input logic [7:0] d);
        BR_Select   = sel;
        Tx_Parallel = d;
        Enable      = 1'b1;
        @(negedge clk);
        Enable = 1'b0;
    endtask

    task automatic wait_done(input string name, input int max);
        int n = 0;
        while (Done !== 1'b1 && n < max) begin
            @(negedge clk);
            n++;
        end
        checks++;
        if (Done !== 1'b1) begin
            errors++;
            $display("FAIL %s: no Done within %0d cycles", name, max);
        end
    endtask

    // Abort a frame after k busy cycles with a one-cycle reset; caller is at busy cycle 1.
    task automatic abort_after(input int k);
        repeat (k - 1) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        check("abort_busy", int'(Busy), 0);
        check("abort_tx", int'(Tx_Serial), 1);
        check("abort_done", int'(Done), 0);
    endtask

    bit   mon_en = 1'b0;
    bit   busy_q = 1'b0;
    bit   have_cur = 1'b0;
    exp_t cur;
    int   busy_len = 0;
    int   lvl_bad = 0;
    int   first_bad = 0;
    int   idle_cnt = 0;
    int   idle_bad = 0;
    int   done_stray = 0;

    always @(negedge clk) begin
        if (mon_en) begin
            if (Busy === 1'b1 && !busy_q) begin
                busy_len = 0;
                lvl_bad  = 0;
                if (sb_q.size() == 0) begin
                    checks++;
                    errors++;
                    have_cur = 1'b0;
                    $display("FAIL unexpected_frame: Busy rose at %0t, expected no frame", $time);
                end else begin
                    cur      = sb_q[0];
                    have_cur = 1'b1;
                    if (cur.gap >= 0) check("idle_gap", idle_cnt, cur.gap);
                end
            end
            if (Busy === 1'b1) begin
                if (have_cur && Tx_Serial !== frame_bit(cur.data, busy_len / cur.bcyc)) begin
                    if (lvl_bad == 0) first_bad = busy_len;
                    lvl_bad++;
                end
                busy_len++;
                if (Done !== 1'b0) done_stray++;
                busy_q = 1'b1;
            end else begin
                if (busy_q) begin
                    if (have_cur) begin
                        void'(sb_q.pop_front());
                        checks++;
                        if (lvl_bad != 0) begin
                            errors++;
                            $display("FAIL frame_bits data=%h: %0d wrong cycles, first at busy cycle %0d, expected 0",
                                     cur.data, lvl_bad, first_bad);
                        end
                        check("busy_len", busy_len, cur.len);
                        check("done_at_end", int'(Done), int'(cur.done));
                    end
                    have_cur = 1'b0;
                    idle_cnt = 1;
                end else begin
                    idle_cnt++;
                    if (Done !== 1'b0) done_stray++;
                end
                if (Tx_Serial !== 1'b1) idle_bad++;
                busy_q = 1'b0;
            end
        end
    end

    initial begin
        #950000;
        $display("FAIL watchdog: simulation did not finish, expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        int bad;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        check("rst_tx", int'(Tx_Serial), 1);
        check("rst_busy", int'(Busy), 0);
        check("rst_done", int'(Done), 0);
        mon_en = 1'b1;
        bad = 0;
        repeat (100) begin
            @(negedge clk);
            if (Tx_Serial !== 1'b1 || Busy !== 1'b0 || Done !== 1'b0) bad++;
        end
        check("idle_100", bad, 0);

        // 115200 frame of A5
        send(3'd7, 8'hA5, -1, -1);
        wait_done("done_a5", NB * 86 + 10);
        repeat (5) @(negedge clk);

        // 9600 frame of 00 with live select/data changed mid-frame
        send(3'd3, 8'h00, -1, -1);
        repeat (3000) @(negedge clk);
        BR_Select   = 3'd7;
        Tx_Parallel = 8'hFF;
        wait_done("done_00", NB * 1041 + 10);
        repeat (5) @(negedge clk);

        // Extra Enables mid-frame must be ignored, not queued
        send(3'd7, 8'h3C, -1, -1);
        repeat (100) @(negedge clk);
        pulse_only(3'd0, 8'hFF);
        repeat (300) @(negedge clk);
        pulse_only(3'd7, 8'h81);
        repeat (300) @(negedge clk);
        Tx_Parallel = 8'h00;
        wait_done("done_3c", NB * 86 + 10);
        repeat (2 * NB * 86) @(negedge clk);

        // Back-to-back: Enable in the Done cycle
        send(3'd7, 8'hFF, -1, -1);
        wait_done("done_ff", NB * 86 + 10);
        send(3'd7, 8'h55, -1, 1);
        wait_done("done_55", NB * 86 + 10);
        repeat (5) @(negedge clk);

        // Reset in the middle of the 4th data bit, then a complete frame
        send(3'd7, 8'hC6, 4 * 86 + 43, -1);
        abort_after(4 * 86 + 43);
        @(negedge clk);
        send(3'd7, 8'h5A, -1, -1);
        wait_done("done_5a", NB * 86 + 10);
        repeat (5) @(negedge clk);

        // Remaining divisor entries: full frames for faster rates
        send(3'd6, 8'h81, -1, -1);
        wait_done("done_sel6", NB * 173 + 10);
        repeat (3) @(negedge clk);
        send(3'd5, 8'h7E, -1, -1);
        wait_done("done_sel5", NB * 260 + 10);
        repeat (3) @(negedge clk);
        send(3'd4, 8'h96, -1, -1);
        wait_done("done_sel4", NB * 520 + 10);
        repeat (3) @(negedge clk);

        // Slow rates: check start bit and first data bit, then abort
        for (int s = 0; s < 3; s++) begin
            send(3'(s), 8'hB7, bcyc_of(3'(s)) + bcyc_of(3'(s)) / 2, -1);
            abort_after(bcyc_of(3'(s)) + bcyc_of(3'(s)) / 2);
            repeat (3) @(negedge clk);
        end

`ifdef UART_TX_PARITY_EN
        send(3'd7, 8'h07, -1, -1);
        wait_done("done_p07", NB * 86 + 10);
        repeat (3) @(negedge clk);
        send(3'd7, 8'h03, -1, -1);
        wait_done("done_p03", NB * 86 + 10);
        repeat (3) @(negedge clk);
`endif

        // Enable coincident with reset: no frame
        rst         = 1'b1;
        Enable      = 1'b1;
        Tx_Parallel = 8'h11;
        @(negedge clk);
        rst    = 1'b0;
        Enable = 1'b0;
        @(negedge clk);
        check("en_rst_busy", int'(Busy), 0);
        repeat (200) @(negedge clk);

        check("sb_empty", sb_q.size(), 0);
        check("idle_line_high", idle_bad, 0);
        check("stray_done", done_stray, 0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/uart_tx_baud.md
Name: uart_tx_baud

Overview:
- Selectable-baud UART transmitter.
- Serialises one 8-bit byte per accepted Enable pulse as 8N1 (or 8E1 with the optional feature), LSB first.
- Bit rate is chosen at frame start by the 3-bit BR_Select switch bank.
- Sits between Debounce_Pulse (Enable source) and the board Tx pin; gives top a usable BR_Select path and Busy/Done status.

Parameters:
- CLK_FREQ, 100000000, system clock frequency in Hz; used to derive per-bit cycle counts.
- CNT_W, 17, bit-counter width; must hold CLK_FREQ/1200 - 1.

Ports:
- clk  input  1  system clock; all logic on rising edge.
- rst  input  1  synchronous, active-high reset.
- BR_Select  input  3  baud select; sampled only when a frame is accepted.
- Tx_Parallel  input  8  byte to send; sampled only when a frame is accepted.
- Enable  input  1  single-cycle start request from the debounced pulse.
- Tx_Serial  output  1  serial line; idle high; registered.
- Busy  output  1  high from the first start-bit cycle through the last stop-bit cycle.
- Done  output  1  one-cycle pulse when a frame completes.

Behaviour:
- Reset values: Tx_Serial=1, Busy=0, Done=0, state=IDLE, counters=0.
- Reset is honoured in any state; a frame in progress is abandoned with no stop bit or Done.
- Baud map, BR_Select 0..7: 1200, 2400, 4800, 9600, 19200, 38400, 57600, 115200.
- BIT_CYC = CLK_FREQ / baud, integer truncation. At 100 MHz: 9600 -> 10416 cycles; 115200 -> 868 cycles.
- Divisor table is combinational from the latched select. Bit counter counts 0..BIT_CYC-1.
- Accept rule:
  - Enable is accepted in any cycle with Busy=0, including the cycle in which Done=1.
  - On acceptance, latch Tx_Parallel into a shift register and latch BR_Select.
  - Enable while Busy=1 is ignored; it is not queued.
- States:
  - IDLE: Tx_Serial=1. On accepted Enable -> START.
  - START: Tx_Serial=0 for BIT_CYC cycles -> DATA.
  - DATA: Tx_Serial = shift[0] for BIT_CYC cycles per bit; shift right after each bit; 3-bit index counts 0..7.
    - After bit 7 -> STOP, or -> PARITY with the feature enabled.
  - STOP: Tx_Serial=1 for BIT_CYC cycles -> IDLE.
- Latency:
  - Enable accepted in cycle N -> Tx_Serial=0 and Busy=1 from cycle N+1.
  - Busy stays high for exactly 10*BIT_CYC cycles (11*BIT_CYC with parity).
  - Done=1 in the first cycle with Busy=0.
- Changes to BR_Select or Tx_Parallel mid-frame have no effect on the current frame.
- Enable coincident with rst: rst wins; no frame starts.
- Back-to-back frames: Enable held or re-pulsed in the Done cycle gives a start bit immediately after the stop bit, with no extra idle cycle.

Optional Feature:
- Macro: UART_TX_PARITY_EN.
- Defined: a PARITY state is inserted between DATA and STOP.
  - Tx_Serial = even parity (XOR of the latched byte) for BIT_CYC cycles.
  - Frame becomes 11 bits; Busy lasts 11*BIT_CYC cycles.
- Undefined: no PARITY state or parity logic is compiled; frame is 8N1, 10 bits.

Test Plan:
- Reset, then hold idle 100 cycles -> Tx_Serial=1, Busy=0, Done=0 throughout.
- BR_Select=7, Tx_Parallel=8'hA5, Enable pulse at cycle N -> Tx_Serial low at N+1 for 868 cycles.
  - Then bits 1,0,1,0,0,1,0,1 at 868 cycles each, then high 868 cycles.
  - Busy high exactly 8680 cycles; Done one-cycle pulse at N+8681.
- BR_Select=3, Tx_Parallel=8'h00 -> start bit plus 8 data bits give 9*10416 low cycles, then stop high.
  - Change BR_Select to 7 mid-frame -> bit timing unchanged.
- Mid-frame extra Enable pulses and Tx_Parallel changes during a 8'h3C frame -> only 8'h3C sent; no second frame.
- Enable in the Done cycle with 8'h55 after an 8'hFF frame at BR_Select=7 -> new start bit begins the cycle after Done; no idle gap.
- rst asserted in the 4th data bit -> next cycle Tx_Serial=1, Busy=0, Done stays 0; a new Enable then sends a complete frame.
  - With UART_TX_PARITY_EN: 8'h07 gives parity bit 1; 8'h03 gives parity bit 0; Busy lasts 9548 cycles at BR_Select=7.
